// File: rtl/cos_harmonic_seq.sv
// Harmonic phase sequencer: for each accepted base phase x, emits k*x (k = 1..P)
// as quarter-wave LUT descriptors (address, quadrant, sign) for a cosine stage.
module cos_harmonic_seq #(
  parameter int PW = 10,
  parameter int AW = PW - 2,
  parameter int P  = 4,
  parameter int KW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [PW-1:0] x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] lut_addr,
  output logic [1:0]    quad_sel,
  output logic          neg,
  output logic [KW-1:0] k_idx,
  output logic          last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [KW-1:0] P_K = KW'(P);

  logic [0:0]    state_reg, state_next;
  logic [PW-1:0] acc_reg, acc_next;
  logic [PW-1:0] step_reg, step_next;
  logic [KW-1:0] k_next;
  logic          load;
  logic [1:0]    q_next;
  logic [AW-1:0] addr_next;
  logic          neg_next;
  logic          last_next;

  assign x_ready   = (state_reg == IDLE);
  assign out_valid = (state_reg == RUN);

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    step_next  = step_reg;
    k_next     = k_idx;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (x_valid) begin
          state_next = RUN;
          acc_next   = x;
          step_next  = x;
          k_next     = KW'(1);
          load       = 1'b1;
        end
      end
      default: begin
        if (out_ready) begin
          if (k_idx == P_K) begin
            state_next = IDLE;
          end else begin
            acc_next = acc_reg + step_reg;
            k_next   = k_idx + KW'(1);
            load     = 1'b1;
          end
        end
      end
    endcase
  end

  // Odd quadrants read the quarter wave mirrored, i.e. the bitwise complement of the offset.
  assign q_next   = acc_next[PW-1:PW-2];
  assign neg_next = q_next[1] ^ q_next[0];

  genvar gi;
  generate
    for (gi = 0; gi < AW; gi++) begin : g_mirror
      assign addr_next[gi] = acc_next[gi] ^ q_next[0];
    end
  endgenerate

  assign last_next = (state_next == RUN) && (k_next == P_K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      step_reg  <= '0;
      k_idx     <= '0;
      quad_sel  <= '0;
      lut_addr  <= '0;
      neg       <= 1'b0;
      last      <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      step_reg  <= step_next;
      last      <= last_next;
      if (load) begin
        k_idx    <= k_next;
        quad_sel <= q_next;
        lut_addr <= addr_next;
        neg      <= neg_next;
      end
    end
  end

endmodule

// File: doc/cos_harmonic_seq.md
COS_HARMONIC_SEQ -- requirements
Module: cos_harmonic_seq

Interface
REQ-001 Parameter PW, default 10: phase width; one full turn (2*pi) = 2^PW codes.
REQ-002 Parameter AW, default PW-2: quarter-wave LUT address width.
REQ-003 Parameter P, default 4: expansion order; harmonics emitted per input sample, P >= 1.
REQ-004 Parameter KW, default 3: harmonic index width, 2^KW > P.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 x_valid  input  1  input sample phase offered.
REQ-008 x_ready  output  1  block accepts x this cycle.
REQ-009 x  input  PW  base phase, unsigned, modulo 2^PW.
REQ-010 out_valid  output  1  harmonic descriptor valid.
REQ-011 out_ready  input  1  downstream cosine LUT/mux stage accepts descriptor.
REQ-012 lut_addr  output  AW  quarter-wave LUT address.
REQ-013 quad_sel  output  2  quadrant of current harmonic phase; drives downstream 4:1 select lines.
REQ-014 neg  output  1  cosine sign: 1 = negate LUT magnitude.
REQ-015 k_idx  output  KW  harmonic number k, 1..P.
REQ-016 last  output  1  high with out_valid when k_idx == P.

Function
REQ-017 The block SHALL implement a two-state FSM, IDLE and RUN.
REQ-018 x_ready SHALL be 1 exactly when state == IDLE; out_valid SHALL be 1 exactly when state == RUN.
REQ-019 IDLE, x_valid=1: SHALL latch step=x, acc=x, k=1, enter RUN next cycle (out_valid at cycle t+1 for acceptance at t).
REQ-020 RUN, out_ready=1, k<P: SHALL update acc = (acc+step) mod 2^PW, k = k+1; no overflow flag.
REQ-021 RUN, out_ready=1, k==P: SHALL return to IDLE; x_ready=1 the following cycle (no same-cycle accept).
REQ-022 RUN, out_ready=0: all outputs and internal state SHALL hold unchanged.
REQ-023 IDLE: x_valid=0 SHALL leave state unchanged; out_ready ignored.
REQ-024 Output fields SHALL be registers, updated in the same edge as acc, never combinational from x.
REQ-025 With q = acc[PW-1:PW-2], o = acc[AW-1:0]: quad_sel SHALL equal q.
REQ-026 q=0: lut_addr=o, neg=0; q=1: lut_addr=2^AW-1-o, neg=1; q=2: lut_addr=o, neg=1; q=3: lut_addr=2^AW-1-o, neg=0.
REQ-027 last SHALL equal (k_idx==P) while out_valid=1, else 0; P=1 gives last=1 on the only beat.
REQ-028 Throughput: one sample per P+1 cycles at out_ready=1; no descriptor dropped or duplicated.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, out_valid=0, x_ready=1, lut_addr=0, quad_sel=0, neg=0, k_idx=0, last=0, acc=0, step=0.
REQ-030 Reset mid-burst SHALL abandon remaining harmonics; first accepted x after release SHALL restart at k=1.

Verification
REQ-031 x=100, out_ready=1: beats (k,quad_sel,lut_addr,neg) = (1,0,100,0),(2,0,200,0),(3,1,211,1),(4,1,111,1), last on 4th; x_ready 1 cycle after.
REQ-032 x=700 (wrap): (1,2,188,1),(2,1,135,1),(3,0,52,0),(4,2,240,1).
REQ-033 x=800: k=1 -> quad_sel=3, lut_addr=223, neg=0; x=0: all four beats lut_addr=0, quad_sel=0, neg=0.
REQ-034 x=100, out_ready low 3 cycles during k=2: outputs hold (2,0,200,0); x_valid pulses ignored; sequence resumes at k=3.
REQ-035 Assert rst_n low during k=3 of x=100: out_valid=0 asynchronously; after release, x=700 yields REQ-032 sequence from k=1.
REQ-036 Back-to-back x_valid held high: each sample accepted only in IDLE; gap of exactly one cycle between last and next k=1 beat.
